// File: rtl/distribute1_4_if.sv
// Handshake bundle between an upstream producer, the 1-to-4 distributor and
// its four downstream consumers.
`ifndef WORDSIZE
`define WORDSIZE 32
`endif

interface distribute1_4_if #(
    parameter int WIDTH = `WORDSIZE
);
    // Upstream side: one word offered per cycle, steered by in_sel
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;

    // Downstream side: channel k lives at out_data[k*WIDTH +: WIDTH]
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic               busy;

    // Environment view: drives the offer and the consumer readiness
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy
    );

    // Distributor view
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/distribute1_4.sv
// 1-to-4 word distributor. Each output channel is a one-entry register
// (valid flag plus data word). A word offered upstream is steered by in_sel
// into its channel; the offer is accepted when that channel is empty or is
// being drained on the same edge. Non-selected channels drain independently.
`ifndef WORDSIZE
`define WORDSIZE 32
`endif

module distribute1_4 #(
    parameter int WIDTH = `WORDSIZE
) (
    input  logic               clk,
    input  logic               rst,
    distribute1_4_if.slave     bus
);

    // Per-channel status gathered into vectors for the shared accept logic
    logic [3:0]         vld_all;
    logic [4*WIDTH-1:0] data_all;

    // Acceptance of the current offer
    logic               sel_free;
    logic               in_ready_w;
    logic               accept;

    // The offer only looks at its own destination channel, so a full,
    // stalled channel blocks the producer even when the other three are
    // empty. Reset forces the block to refuse every offer.
    always_comb begin
        sel_free   = ~vld_all[bus.in_sel] | bus.out_ready[bus.in_sel];
        in_ready_w = ~rst & sel_free;
        accept     = bus.in_valid & in_ready_w;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_chan
            logic             vld_q;
            logic             vld_d;
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;
            logic             load_hit;
            logic             drain;

            // Loading wins over draining, so a same-edge drain and reload
            // hands the old word out and keeps the new one valid.
            always_comb begin
                load_hit = accept & (bus.in_sel == 2'(gi));
                drain    = vld_q & bus.out_ready[gi];
                vld_d    = vld_q;
                data_d   = data_q;
                if (load_hit) begin
                    vld_d  = 1'b1;
                    data_d = bus.in_data;
                end else if (drain) begin
                    vld_d  = 1'b0;
                end
            end

            // Channel register; reset discards the held word and zeroes data
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q  <= 1'b0;
                    data_q <= '0;
                end else begin
                    vld_q  <= vld_d;
                    data_q <= data_d;
                end
            end

            assign vld_all[gi]                    = vld_q;
            assign data_all[gi*WIDTH +: WIDTH]    = data_q;
        end
    endgenerate

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = vld_all;
    assign bus.out_data  = data_all;
    assign bus.busy      = |vld_all;

endmodule

// File: tb/tb_distribute1_4.sv
// Directed table plus streaming and randomized scoreboard checks for the
// 1-to-4 distributor at WIDTH=32.
module tb_distribute1_4;

    localparam int W = 32;

    logic clk;
    logic rst;

    distribute1_4_if #(.WIDTH(W)) bus ();

    distribute1_4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         rst;
        logic         iv;
        logic [1:0]   sel;
        logic [31:0]  din;
        logic [3:0]   ordy;
        logic         e_ir;
        logic [3:0]   e_ov;
        logic [127:0] e_od;
        logic         e_busy;
    } vec_t;

    vec_t vecs [12];

    // Scoreboard and reference state for the random phase
    logic [31:0] sb [4][$];
    logic [3:0]  m_vld;
    logic        stalled;
    logic [3:0]  hold_mask;
    logic [127:0] hold_data;
    logic        exp_ir;
    logic [31:0] front;

    initial begin
        //                rst iv sel din            ordy     ir  ov       out_data                                        busy
        vecs[0]  = '{1'b1, 1'b1, 2'd0, 32'hDEAD_0000, 4'b0000, 1'b0, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0},                   1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'd2, 32'hA5A5_0001, 4'b0000, 1'b1, 4'b0100, {32'h0, 32'hA5A5_0001, 32'h0, 32'h0},           1'b1};
        vecs[2]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0011, 4'b0000, 1'b1, 4'b0110, {32'h0, 32'hA5A5_0001, 32'h11, 32'h0},          1'b1};
        vecs[3]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0002, 4'b0000, 1'b0, 4'b0110, {32'h0, 32'hA5A5_0001, 32'h11, 32'h0},          1'b1};
        vecs[4]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0002, 4'b0010, 1'b1, 4'b0110, {32'h0, 32'hA5A5_0001, 32'h2, 32'h0},           1'b1};
        vecs[5]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0030, 4'b0000, 1'b1, 4'b0111, {32'h0, 32'hA5A5_0001, 32'h2, 32'h30},          1'b1};
        vecs[6]  = '{1'b0, 1'b1, 2'd3, 32'h0000_0033, 4'b0000, 1'b1, 4'b1111, {32'h33, 32'hA5A5_0001, 32'h2, 32'h30},         1'b1};
        vecs[7]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0040, 4'b0000, 1'b0, 4'b1111, {32'h33, 32'hA5A5_0001, 32'h2, 32'h30},         1'b1};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0040, 4'b0101, 1'b1, 4'b1011, {32'h33, 32'hA5A5_0001, 32'h2, 32'h40},         1'b1};
        vecs[9]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0050, 4'b0000, 1'b1, 4'b1011, {32'h33, 32'hA5A5_0001, 32'h2, 32'h40},         1'b1};
        vecs[10] = '{1'b1, 1'b1, 2'd2, 32'hDEAD_BEEF, 4'b1111, 1'b0, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0},                   1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'd3, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0},                   1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 4'b0000;

        // Directed table: drive on the falling edge, check in_ready before
        // the rising edge and the registered outputs just after it.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            bus.in_valid  = vecs[i].iv;
            bus.in_sel    = vecs[i].sel;
            bus.in_data   = vecs[i].din;
            bus.out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d in_ready", i), 128'(bus.in_ready), 128'(vecs[i].e_ir));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), 128'(bus.out_valid), 128'(vecs[i].e_ov));
            chk($sformatf("vec%0d out_data", i), bus.out_data, vecs[i].e_od);
            chk($sformatf("vec%0d busy", i), 128'(bus.busy), 128'(vecs[i].e_busy));
            $display("vec%0d rst=%0b iv=%0b sel=%0d din=%h ordy=%b -> ov=%b busy=%0b",
                     i, vecs[i].rst, vecs[i].iv, vecs[i].sel, vecs[i].din, vecs[i].ordy,
                     bus.out_valid, bus.busy);
        end

        // Empty block right after reset: every destination is accepted
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s);
            #1;
            chk($sformatf("post-reset in_ready sel%0d", s), 128'(bus.in_ready), 128'(1'b1));
        end

        // Streaming: one word per cycle round-robin, every consumer ready
        for (int i = 0; i < 8; i++) begin
            logic [3:0]  onehot;
            logic [31:0] word;
            @(negedge clk);
            word          = 32'h10 + 32'(i);
            bus.in_valid  = 1'b1;
            bus.in_sel    = 2'(i % 4);
            bus.in_data   = word;
            bus.out_ready = 4'b1111;
            #1;
            chk($sformatf("stream%0d in_ready", i), 128'(bus.in_ready), 128'(1'b1));
            @(posedge clk);
            #1;
            onehot = 4'b0001 << (i % 4);
            chk($sformatf("stream%0d out_valid", i), 128'(bus.out_valid), 128'(onehot));
            chk($sformatf("stream%0d word", i), 128'(bus.out_data[(i % 4)*32 +: 32]), 128'(word));
            $display("stream%0d sel=%0d word=%h ov=%b", i, i % 4, word, bus.out_valid);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stream drained", 128'(bus.out_valid), 128'(4'b0000));

        // Random traffic against a four-queue scoreboard
        m_vld   = 4'b0000;
        stalled = 1'b0;
        for (int cyc = 0; cyc < 10006; cyc++) begin
            logic acc;
            @(negedge clk);
            if (!stalled) begin
                if (cyc < 10000) begin
                    bus.in_valid = ($urandom_range(0, 3) != 0);
                    bus.in_sel   = 2'($urandom_range(0, 3));
                    bus.in_data  = $urandom;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = (cyc < 10000) ? 4'($urandom_range(0, 15)) : 4'b1111;
            #1;
            exp_ir = ~m_vld[bus.in_sel] | bus.out_ready[bus.in_sel];
            chk("rand in_ready", 128'(bus.in_ready), 128'(exp_ir));
            chk("rand out_valid", 128'(bus.out_valid), 128'(m_vld));
            acc = bus.in_valid & exp_ir;
            // Pop delivered words before pushing the new one
            for (int k = 0; k < 4; k++) begin
                if (m_vld[k] && bus.out_ready[k]) begin
                    if (sb[k].size() == 0) begin
                        chk($sformatf("rand ch%0d unexpected word", k), 128'(bus.out_data[k*32 +: 32]), 128'hx);
                    end else begin
                        front = sb[k].pop_front();
                        chk($sformatf("rand ch%0d word", k), 128'(bus.out_data[k*32 +: 32]), 128'(front));
                    end
                end
            end
            if (acc) sb[bus.in_sel].push_back(bus.in_data);
            hold_mask = bus.out_valid & ~bus.out_ready;
            hold_data = bus.out_data;
            stalled   = bus.in_valid & ~exp_ir;
            for (int k = 0; k < 4; k++) begin
                if (acc && bus.in_sel == 2'(k)) m_vld[k] = 1'b1;
                else if (m_vld[k] && bus.out_ready[k]) m_vld[k] = 1'b0;
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (hold_mask[k]) begin
                    chk($sformatf("rand ch%0d held valid", k), 128'(bus.out_valid[k]), 128'(1'b1));
                    chk($sformatf("rand ch%0d held data", k), 128'(bus.out_data[k*32 +: 32]),
                        128'(hold_data[k*32 +: 32]));
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rand ch%0d leftover words", k), 128'(sb[k].size()), 128'(0));
        end
        chk("rand final out_valid", 128'(bus.out_valid), 128'(4'b0000));
        $display("random phase done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/distribute1_4.md
DISTRIBUTE1_4 -- requirements
Module: distribute1_4

Interface
REQ-001 Parameter: WIDTH, default `WORDSIZE (from defines.v), data word width in bits.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 Port: rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 Port: in_data  input  WIDTH  word offered by the upstream producer.
REQ-005 Port: in_sel  input  2  destination channel (00 ch0, 01 ch1, 10 ch2, 11 ch3), same encoding as the team's 4-1 selector.
REQ-006 Port: in_valid  input  1  upstream offers in_data/in_sel this cycle.
REQ-007 Port: in_ready  output  1  block accepts the offered word this cycle.
REQ-008 Port: out_data  output  4*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port: out_valid  output  4  bit k: channel k holds a valid word.
REQ-010 Port: out_ready  input  4  bit k: consumer k takes its word this cycle.
REQ-011 Port: busy  output  1  OR of out_valid.

Function
REQ-012 Each channel SHALL hold a one-entry register: vld[k] plus data[k], driven directly onto out_valid[k] and out_data slice k.
REQ-013 Transfer-in SHALL occur on a rising edge where in_valid=1 and in_ready=1; transfer-out on channel k where out_valid[k]=1 and out_ready[k]=1.
REQ-014 in_ready SHALL be combinational: in_ready = ~vld[in_sel] | out_ready[in_sel]. It SHALL NOT depend on in_valid, and SHALL NOT depend on the state of non-selected channels.
REQ-015 Latency: a word accepted at edge N SHALL appear on out_valid/out_data of channel in_sel immediately after edge N, i.e. one cycle.
REQ-016 Per channel k, per edge: accept to k -> data[k]=in_data and vld[k]=1, whether or not a transfer-out occurs on the same edge; else transfer-out -> vld[k]=0; else hold.
REQ-017 A simultaneous transfer-out and load on the same channel SHALL leave vld[k]=1 with the new word, and SHALL neither lose nor duplicate a word.
REQ-018 Transfer-outs on non-selected channels SHALL proceed independently on the same edge as an accept.
REQ-019 data[k] SHALL hold its last value when vld[k]=0. Consumers SHALL ignore out_data when out_valid is low.
REQ-020 Words to the same channel SHALL be delivered in acceptance order. No ordering SHALL be guaranteed across channels.
REQ-021 Upstream SHALL keep in_data/in_sel stable while in_valid=1 and in_ready=0. The block SHALL NOT store a rejected word.
REQ-022 When the selected channel is full and its out_ready=0, in_ready SHALL be 0 (head-of-line stall), even if other channels are empty.
REQ-023 out_valid[k] SHALL NOT drop without a transfer-out on channel k, and out_data slice k SHALL NOT change while out_valid[k]=1 and out_ready[k]=0.
REQ-024 busy SHALL be combinational from vld, with no extra delay.

Reset
REQ-025 While rst=1 at a rising edge, all vld SHALL clear to 0 and all data SHALL clear to 0. out_valid=4'b0000, out_data=0 and busy=0 SHALL hold in the cycle after the edge.
REQ-026 During rst=1, in_ready SHALL be driven 0. Words offered during reset SHALL be discarded.
REQ-027 Reset asserted mid-operation SHALL discard all held words, and no transfer-out SHALL complete on that edge.
REQ-028 After rst deasserts, in_ready SHALL be 1 in the first cycle for any in_sel.

Verification (WIDTH=32)
REQ-029 Scenario: reset, then in_valid=1, in_sel=10, in_data=32'hA5A5_0001, out_ready=0000 for 1 edge -> next cycle out_valid=0100, slice 2=32'hA5A5_0001, busy=1, others 0.
REQ-030 Scenario: ch1 full, out_ready=0000, offer in_sel=01, data 32'h0000_0002 -> in_ready=0 and ch1 keeps its old word. Then raise out_ready[1] -> in_ready=1, and after the edge ch1 holds 32'h0000_0002 with out_valid[1]=1.
REQ-031 Scenario: ch0 full and stalled, offer in_sel=11 -> in_ready=1 and ch3 loads. Offer in_sel=00 -> in_ready=0.
REQ-032 Scenario: stream 8 words 32'h10..32'h17 with in_sel cycling 00,01,10,11 and out_ready=1111 every cycle -> one accept per cycle, each word on its channel exactly once, and each channel sees its two words in order.
REQ-033 Scenario: all four channels full, assert rst for 1 edge with in_valid=1 -> out_valid=0000, out_data=0, busy=0, and the offered word is not stored.
REQ-034 Scenario: random in_valid/in_sel/out_ready for 10k cycles, checked against a scoreboard of four FIFOs -> no loss, duplication or reordering, and REQ-023 holds every cycle.
